aes_block_packer: RTL

//   Input stage placed directly upstream of AES_pipe. Packs a 32-bit word stream into
//   128-bit plaintext blocks, then presents one block per cycle on AES_pipe's plaintext

---
 rtl/aes_block_packer_if.sv | 22 ++
 rtl/aes_block_packer.sv | 103 ++++++++++
 2 files changed

// File: rtl/aes_block_packer_if.sv
// Word-stream handshake feeding the AES block packer.
// The producer drives word/valid/last; the packer returns ready.
interface aes_block_packer_if;
    logic [31:0] in_word;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;

    modport master (
        output in_word,
        output in_valid,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_word,
        input  in_valid,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/aes_block_packer.sv
// Packs 32-bit words into big-endian 128-bit AES plaintext blocks.
// A valid delay line marks which AES_pipe output cycles carry real ciphertext.
module aes_block_packer #(
    parameter int LATENCY = 10,
    parameter int CNT_W   = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    aes_block_packer_if.slave    in_if,
    output logic [127:0]         plaintext,
    output logic                 pt_valid,
    output logic                 ct_valid,
    output logic [CNT_W-1:0]     block_cnt
);

    typedef enum logic [1:0] {
        EMPTY,
        FILL1,
        FILL2,
        FILL3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [95:0]        buf_q;
    logic               rdy_q;
    logic               acc;
    logic               issue;
    logic [127:0]       blk;
    logic [LATENCY-1:0] vld_q;

    assign in_if.in_ready = rdy_q;
    assign acc            = in_if.in_valid & rdy_q;
    assign ct_valid       = vld_q[LATENCY-1];

    // Current word is merged into the buffered prefix; low words stay zero.
    always_comb begin
        state_d = state_q;
        blk     = '0;
        issue   = 1'b0;
        unique case (state_q)
            EMPTY: begin
                blk = {in_if.in_word, 96'b0};
                if (acc) state_d = FILL1;
            end
            FILL1: begin
                blk = {buf_q[95:64], in_if.in_word, 64'b0};
                if (acc) state_d = FILL2;
            end
            FILL2: begin
                blk = {buf_q[95:32], in_if.in_word, 32'b0};
                if (acc) state_d = FILL3;
            end
            FILL3: begin
                blk   = {buf_q, in_if.in_word};
                issue = acc;
                if (acc) state_d = EMPTY;
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        if (acc && in_if.in_last) begin
            issue   = 1'b1;
            state_d = EMPTY;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= EMPTY;
            buf_q     <= '0;
            rdy_q     <= 1'b0;
            plaintext <= '0;
            pt_valid  <= 1'b0;
            block_cnt <= '0;
        end else begin
            state_q  <= state_d;
            rdy_q    <= 1'b1;
            pt_valid <= issue;
            if (acc) buf_q <= blk[127:32];
            if (issue) begin
                plaintext <= blk;
                block_cnt <= block_cnt + 1'b1;
            end
        end
    end

    generate
        if (LATENCY == 1) begin : g_vld1
            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) vld_q <= '0;
                else      vld_q <= pt_valid;
            end
        end else begin : g_vldn
            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) vld_q <= '0;
                else      vld_q <= {vld_q[LATENCY-2:0], pt_valid};
            end
        end
    endgenerate

endmodule
